// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// Holds the loader FSM encoding and the length clamp helper.
package imem_pkg;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_WORD_W = 32;
  localparam int IMEM_CNT_W  = 9;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_COLLECT,
    LD_WRITE,
    LD_DONE
  } imem_ld_state_t;

  function automatic logic [IMEM_CNT_W-1:0] clampLen(
    input logic [IMEM_CNT_W-1:0] req,
    input logic [IMEM_CNT_W-1:0] maxLen
  );
    return (req > maxLen) ? maxLen : req;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian 4-byte assembly register; packedWord includes the byte being accepted.
// wordFull is combinational from accept, so the caller captures the word on that same edge.
module byte_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             inByte,
  output logic [IMEM_WORD_W-1:0] packedWord,
  output logic                   wordFull
);

  logic [23:0] shiftReg;
  logic [1:0]  byteIdx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shiftReg <= '0;
      byteIdx  <= '0;
    end else if (accept) begin
      shiftReg <= {shiftReg[15:0], inByte};
      byteIdx  <= byteIdx + 2'd1;
    end
  end

  // Earlier bytes have already shifted up, so the first byte ends in the MSB.
  assign packedWord = {shiftReg, inByte};
  assign wordFull   = accept && (byteIdx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit instruction words and writes them at consecutive addresses.
// One write cycle per 4 bytes (5 cycles/word); InReady is low outside COLLECT so the source holds.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic [IMEM_CNT_W-1:0]  WordCount,
  input  logic [7:0]             InByte,
  input  logic                   InValid,
  output logic                   InReady,
  output logic                   MemWrEn,
  output logic [31:0]            MemAddr,
  output logic [IMEM_WORD_W-1:0] MemData,
  output logic                   Busy,
  output logic                   Done,
  output logic [IMEM_CNT_W-1:0]  WordsLoaded
);

  imem_ld_state_t state, nextState;

  logic [IMEM_CNT_W-1:0]  len;
  logic [IMEM_CNT_W-1:0]  wordIdx;
  logic [IMEM_CNT_W-1:0]  reqLen;
  logic [IMEM_WORD_W-1:0] packedWord;
  logic                   wordFull;
  logic                   accept;
  logic                   startLoad;

  assign reqLen    = clampLen(WordCount, IMEM_CNT_W'(DEPTH));
  assign startLoad = (state == LD_IDLE) && Start;
  assign accept    = InValid && InReady;

  byte_packer packer (
    .clk       (Clk),
    .rst       (Rst),
    .clear     (startLoad),
    .accept    (accept),
    .inByte    (InByte),
    .packedWord(packedWord),
    .wordFull  (wordFull)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= LD_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      LD_IDLE:    if (Start) nextState = (reqLen == '0) ? LD_DONE : LD_COLLECT;
      LD_COLLECT: if (wordFull) nextState = LD_WRITE;
      LD_WRITE:   nextState = (wordIdx + 1'b1 == len) ? LD_DONE : LD_COLLECT;
      LD_DONE:    nextState = LD_IDLE;
      default:    nextState = LD_IDLE;
    endcase
  end

  always_comb begin
    InReady = (state == LD_COLLECT);
    MemWrEn = (state == LD_WRITE);
    Busy    = (state != LD_IDLE);
    Done    = (state == LD_DONE);
  end

  // Address and data are captured as the 4th byte lands so they are stable for the whole WRITE cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      len     <= '0;
      wordIdx <= '0;
      MemAddr <= '0;
      MemData <= '0;
    end else begin
      if (startLoad) begin
        len     <= reqLen;
        wordIdx <= '0;
      end
      if (wordFull) begin
        MemAddr <= BASE_ADDR + {{(32-IMEM_CNT_W-2){1'b0}}, wordIdx, 2'b00};
        MemData <= packedWord;
      end
      if (state == LD_WRITE) wordIdx <= wordIdx + 1'b1;
    end
  end

  // The word index and the reported count advance together.
  assign WordsLoaded = wordIdx;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes queued with the stream, popped on MemWrEn.
module tb_imem_loader;
  import imem_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [8:0]  WordCount;
  logic [7:0]  InByte;
  logic        InValid;
  logic        InReady;
  logic        MemWrEn;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        Busy;
  logic        Done;
  logic [8:0]  WordsLoaded;

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .WordCount(WordCount),
    .InByte(InByte), .InValid(InValid), .InReady(InReady),
    .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemData(MemData),
    .Busy(Busy), .Done(Done), .WordsLoaded(WordsLoaded)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          startCyc = 0;
  int          wrCnt = 0;
  int          doneCnt = 0;
  int          accCnt = 0;
  int          wrCycles[$];
  logic [31:0] lastAddr;
  logic [7:0]  stream[$];
  wr_t         sb[$];
  wr_t         monExp;
  logic [31:0] mem[0:255];

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  initial forever begin
    @(negedge Clk);
    if (Rst) begin
      accCnt = 0;
    end else begin
      if (MemWrEn) begin
        wrCnt++;
        wrCycles.push_back(cyc);
        lastAddr = MemAddr;
        if (MemAddr < 32'd1024) mem[MemAddr[9:2]] = MemData;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h, required no write", MemAddr, MemData);
        end else begin
          monExp = sb.pop_front();
          if (MemAddr !== monExp.addr || MemData !== monExp.data) begin
            errors++;
            $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                     MemAddr, MemData, monExp.addr, monExp.data);
          end
        end
        checks++;
        if (accCnt !== 4 || InReady !== 1'b0) begin
          errors++;
          $display("FAIL write_qual: got bytes=%0d InReady=%b, required bytes=4 InReady=0", accCnt, InReady);
        end
        accCnt = 0;
      end
      if (InValid && InReady) accCnt++;
      if (Done) doneCnt++;
    end
  end

  task automatic push_word(input logic [31:0] w, input int idx);
    wr_t e;
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
    e.addr = 32'(idx) << 2;
    e.data = w;
    sb.push_back(e);
  endtask

  task automatic start_load(input int wc);
    Start = 1'b1;
    WordCount = 9'(wc);
    @(posedge Clk); #1;
    startCyc = cyc;
    Start = 1'b0;
  endtask

  // Offers queued bytes until all are accepted; InValid optionally gapped.
  task automatic drive_stream(input bit gapped);
    int  n = 0;
    bit  xfer;
    while (stream.size() > 0 && n < 10000) begin
      InByte  = stream[0];
      InValid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge Clk);
      xfer = InValid && InReady;
      @(posedge Clk); #1;
      if (xfer) void'(stream.pop_front());
      n++;
    end
    InValid = 1'b0;
    checks++;
    if (stream.size() !== 0) begin
      errors++;
      $display("FAIL stream_timeout: got %0d bytes left, required 0", stream.size());
      stream.delete();
    end
  endtask

  task automatic wait_done(input int maxCyc, output int doneAt);
    int n = 0;
    doneAt = -1;
    while (n < maxCyc) begin
      @(negedge Clk);
      n++;
      if (Done === 1'b1) begin
        doneAt = cyc;
        break;
      end
    end
    @(posedge Clk); #1;
    checks++;
    if (doneAt < 0) begin
      errors++;
      $display("FAIL done_timeout: got no Done in %0d cycles, required Done", maxCyc);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 1'b0; WordCount = '0; InByte = '0; InValid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({InReady, MemWrEn, Busy, Done, MemAddr, MemData, WordsLoaded} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b wr=%b busy=%b done=%b addr=%h data=%h wl=%0d, required all 0",
               InReady, MemWrEn, Busy, Done, MemAddr, MemData, WordsLoaded);
    end
    Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    int w0 = wrCnt, d0 = doneCnt, doneAt, s;
    wrCycles.delete();
    push_word(32'h12345678, 0);
    push_word(32'h9ABCDEF0, 1);
    start_load(2);
    s = startCyc;
    checks++;
    if (Busy !== 1'b1 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: got Busy=%b InReady=%b, required 1/1", Busy, InReady);
    end
    drive_stream(1'b0);
    wait_done(50, doneAt);
    checks++;
    if (wrCnt - w0 !== 2 || wrCycles.size() !== 2) begin
      errors++;
      $display("FAIL basic_count: got %0d writes, required 2", wrCnt - w0);
    end else begin
      checks++;
      if (wrCycles[0] !== s + 4 || wrCycles[1] !== s + 9 || doneAt !== s + 10) begin
        errors++;
        $display("FAIL basic_timing: got wr=%0d,%0d done=%0d, required %0d,%0d,%0d",
                 wrCycles[0] - s, wrCycles[1] - s, doneAt - s, 4, 9, 10);
      end
    end
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || WordsLoaded !== 9'd2 || doneCnt - d0 !== 1 || sb.size() !== 0) begin
      errors++;
      $display("FAIL basic_end: got Busy=%b Done=%b wl=%0d dones=%0d sb=%0d, required 0 0 2 1 0",
               Busy, Done, WordsLoaded, doneCnt - d0, sb.size());
    end
  endtask

  task automatic test_gapped();
    int w0 = wrCnt, d0 = doneCnt, doneAt;
    push_word(32'h12345678, 0);
    push_word(32'h9ABCDEF0, 1);
    start_load(2);
    drive_stream(1'b1);
    wait_done(100, doneAt);
    checks++;
    if (wrCnt - w0 !== 2 || WordsLoaded !== 9'd2 || doneCnt - d0 !== 1 || sb.size() !== 0) begin
      errors++;
      $display("FAIL gapped: got writes=%0d wl=%0d dones=%0d sb=%0d, required 2 2 1 0",
               wrCnt - w0, WordsLoaded, doneCnt - d0, sb.size());
    end
  endtask

  task automatic test_zero_length();
    int w0 = wrCnt;
    start_load(0);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b1 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got Done=%b Busy=%b InReady=%b, required 1 1 0", Done, Busy, InReady);
    end
    @(posedge Clk); #1;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got Done=%b Busy=%b, required 0 0", Done, Busy);
    end
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (wrCnt !== w0 || WordsLoaded !== 9'd0) begin
      errors++;
      $display("FAIL zero_nowrite: got writes=%0d wl=%0d, required 0 0", wrCnt - w0, WordsLoaded);
    end
  endtask

  task automatic test_clamp();
    int w0 = wrCnt, doneAt, a;
    logic [31:0] expW;
    for (int i = 0; i < 256; i++)
      push_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, i);
    start_load(300);
    drive_stream(1'b0);
    wait_done(100, doneAt);
    checks++;
    if (wrCnt - w0 !== 256 || lastAddr !== 32'h3FC || WordsLoaded !== 9'd256 || sb.size() !== 0) begin
      errors++;
      $display("FAIL clamp: got writes=%0d last=%h wl=%0d sb=%0d, required 256 3fc 256 0",
               wrCnt - w0, lastAddr, WordsLoaded, sb.size());
    end
    for (int k = 0; k < 32; k++) begin
      a = $urandom_range(0, 255);
      expW = {8'(4*a), 8'(4*a+1), 8'(4*a+2), 8'(4*a+3)};
      checks++;
      if (mem[a] !== expW) begin
        errors++;
        $display("FAIL clamp_readback[%0d]: got %h, required %h", a, mem[a], expW);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int w0 = wrCnt, doneAt;
    stream.push_back(8'h11);
    stream.push_back(8'h22);
    start_load(2);
    drive_stream(1'b0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if ({InReady, MemWrEn, Busy, Done, MemAddr, MemData, WordsLoaded} !== '0 || wrCnt !== w0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b wr=%b busy=%b done=%b addr=%h data=%h wl=%0d writes=%0d, required all 0",
               InReady, MemWrEn, Busy, Done, MemAddr, MemData, WordsLoaded, wrCnt - w0);
    end
    Rst = 1'b0;
    @(posedge Clk); #1;
    push_word(32'hA1B2C3D4, 0);
    start_load(1);
    drive_stream(1'b0);
    wait_done(50, doneAt);
    checks++;
    if (wrCnt - w0 !== 1 || WordsLoaded !== 9'd1 || sb.size() !== 0) begin
      errors++;
      $display("FAIL midreset_reload: got writes=%0d wl=%0d sb=%0d, required 1 1 0",
               wrCnt - w0, WordsLoaded, sb.size());
    end
  endtask

  task automatic test_ignored_start();
    int w0 = wrCnt, d0 = doneCnt, doneAt;
    push_word(32'hCAFEBABE, 0);
    push_word(32'hDEADBEEF, 1);
    start_load(2);
    fork
      drive_stream(1'b0);
      begin
        repeat (3) @(posedge Clk);
        #1;
        Start = 1'b1;
        WordCount = 9'd5;
        @(posedge Clk); #1;
        Start = 1'b0;
      end
    join
    wait_done(50, doneAt);
    repeat (10) @(posedge Clk);
    #1;
    checks++;
    if (wrCnt - w0 !== 2 || doneCnt - d0 !== 1 || WordsLoaded !== 9'd2 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: got writes=%0d dones=%0d wl=%0d Busy=%b, required 2 1 2 0",
               wrCnt - w0, doneCnt - d0, WordsLoaded, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_zero_length();
    test_clamp();
    test_reset_mid_word();
    test_ignored_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
